// File: rtl/round_scheduler.sv
// -----------------------------------------------------------------------------
// round_scheduler
//
// Top-level sequencer for the Keccak-style permutation over the 64 x 25-bit
// state memory. For each of NUM_ROUNDS rounds it launches the NUM_STEPS step
// units (theta, rho, pi, chi, iota) strictly in order. Each unit gets a level
// enable and the sequencer waits for that unit's done. A one-cycle LAUNCH gap
// with every enable low precedes each step so the shared memory port can turn
// around before the next owner starts.
//
// Optional feature (compile-time macro STEP_TIMEOUT_EN):
//   defined     - a per-step wait counter aborts a step that stays in WAIT for
//                 TIMEOUT_CYCLES cycles. The sequencer returns to IDLE without a
//                 done pulse and raises the sticky o_timeout_err.
//   not defined - no counter is built, WAIT waits indefinitely and
//                 o_timeout_err is tied low.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset, overrides everything
//   i_start        request one full permutation, only sampled while idle
//   i_step_done    done pulses from the step units, bit i = unit i
//   o_step_en      one-hot level enable to the active unit (zero otherwise)
//   o_mem_sel      index of the unit owning the shared state-memory port
//   o_round_idx    current round, 0..NUM_ROUNDS-1, for the round-constant logic
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse at the end of the permutation
//   o_timeout_err  sticky step-timeout flag
// -----------------------------------------------------------------------------
module round_scheduler #(
    parameter int unsigned NUM_ROUNDS     = 24,
    parameter int unsigned NUM_STEPS      = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
    localparam int unsigned SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NUM_STEPS-1:0] i_step_done,
    output logic [NUM_STEPS-1:0] o_step_en,
    output logic [2:0]           o_mem_sel,
    output logic [RW-1:0]        o_round_idx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout_err
);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StFinish
    } state_e;

    localparam logic [SW-1:0] LAST_STEP  = SW'(NUM_STEPS - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [SW-1:0] r_step;
    logic [SW-1:0] w_step_nxt;
    logic [RW-1:0] r_round;
    logic [RW-1:0] w_round_nxt;

    // Only the active unit's done bit matters; the others are don't-care.
    logic          w_cur_done;
    assign w_cur_done = i_step_done[r_step];

`ifdef STEP_TIMEOUT_EN
    localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WCW-1:0] r_wait_cnt;
    logic           r_timeout_err;
    logic           w_timeout_hit;

    // The final idle WAIT cycle is the one where the count already equals
    // TIMEOUT_CYCLES-1, so the abort takes effect exactly TIMEOUT_CYCLES
    // cycles after WAIT entry.
    assign w_timeout_hit = (r_state == StWait) && !w_cur_done &&
                           (r_wait_cnt == WCW'(TIMEOUT_CYCLES - 1));
`else
    // The timeout length has no meaning when the counter is not built.
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
`endif

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_step  <= '0;
            r_round <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_round <= w_round_nxt;
        end
    end

`ifdef STEP_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            // LAUNCH always precedes WAIT, so clearing here restarts the count
            // on every WAIT entry.
            if (r_state == StLaunch) begin
                r_wait_cnt <= '0;
            end else if ((r_state == StWait) && !w_cur_done) begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end

            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end else if ((r_state == StIdle) && i_start) begin
                r_timeout_err <= 1'b0;
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and counter update
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_round_nxt = r_round;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StLaunch;
                    w_step_nxt  = '0;
                    w_round_nxt = '0;
                end
            end

            StLaunch: begin
                w_state_nxt = StWait;
            end

            StWait: begin
                if (w_cur_done) begin
                    if (r_step != LAST_STEP) begin
                        w_step_nxt  = r_step + SW'(1);
                        w_state_nxt = StLaunch;
                    end else if (r_round != LAST_ROUND) begin
                        w_round_nxt = r_round + RW'(1);
                        w_step_nxt  = '0;
                        w_state_nxt = StLaunch;
                    end else begin
                        w_state_nxt = StFinish;
                    end
                end
`ifdef STEP_TIMEOUT_EN
                else if (w_timeout_hit) begin
                    w_state_nxt = StIdle;
                end
`endif
            end

            StFinish: begin
                w_state_nxt = StIdle;
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (Moore): everything idles to zero outside an active run
    // -------------------------------------------------------------------------
    always_comb begin
        o_step_en   = '0;
        o_mem_sel   = '0;
        o_round_idx = '0;
        o_busy      = 1'b0;
        o_done      = 1'b0;

        unique case (r_state)
            StIdle: begin
            end

            StLaunch: begin
                o_mem_sel   = 3'(r_step);
                o_round_idx = r_round;
                o_busy      = 1'b1;
            end

            StWait: begin
                o_step_en   = NUM_STEPS'(1) << r_step;
                o_mem_sel   = 3'(r_step);
                o_round_idx = r_round;
                o_busy      = 1'b1;
            end

            StFinish: begin
                o_mem_sel   = 3'(r_step);
                o_round_idx = r_round;
                o_busy      = 1'b1;
                o_done      = 1'b1;
            end

            default: begin
            end
        endcase
    end

`ifdef STEP_TIMEOUT_EN
    assign o_timeout_err = r_timeout_err;
`else
    assign o_timeout_err = 1'b0;
`endif

endmodule

// File: doc/round_scheduler.md
Name: round_scheduler

Overview:
Top-level sequencer for the Keccak-style permutation over the 64-line x 25-bit state memory. It launches the five step units (0 theta/column parity, 1 rho/rotate, 2 pi/permute, 3 chi/revaluate, 4 iota/addRC) in order. Each unit gets a level enable and the scheduler waits for that unit's done. This repeats for NUM_ROUNDS rounds. It also owns the shared memory-port select and supplies the round index to the round-constant logic.

Parameters:
NUM_ROUNDS, 24, permutation rounds per start
NUM_STEPS, 5, step units per round (fixed order 0..NUM_STEPS-1)
TIMEOUT_CYCLES, 255, max WAIT cycles per step (used only with STEP_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request one full permutation; sampled only in IDLE
step_done  input  NUM_STEPS  done pulses from step units, bit i = unit i
step_en  output  NUM_STEPS  one-hot level enable to the active unit (e.g. addrc_en on bit 4)
mem_sel  output  3  index of the unit owning the shared state-memory port
round_idx  output  $clog2(NUM_ROUNDS)  current round, 0..NUM_ROUNDS-1
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at permutation end
timeout_err  output  1  sticky step-timeout flag; constant 0 without STEP_TIMEOUT_EN

Behaviour:
- Single clock domain.
- Reset: rst is synchronous and active-high and overrides everything, including mid-run.
  - State goes to IDLE.
  - step_en=0, mem_sel=0, round_idx=0, busy=0, done=0, timeout_err=0.
  - Internal step/round counters clear.
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE:
  - All outputs idle.
  - start=1 -> LAUNCH with step=0, round=0.
- LAUNCH (exactly 1 cycle, memory turnaround):
  - step_en=0; mem_sel=step; round_idx=round.
  - Always -> WAIT.
- WAIT:
  - step_en[step]=1; all other bits 0; mem_sel held.
  - Only step_done[step] is sampled; done bits of inactive units are ignored.
  - On step_done[step]=1:
    - step<NUM_STEPS-1 -> step+1, LAUNCH.
    - Else if round<NUM_ROUNDS-1 -> round+1, step=0, LAUNCH.
    - Else -> FINISH.
  - step_en drops in the cycle after step_done is seen.
- FINISH:
  - done=1 for one cycle, busy=1.
  - -> IDLE. round_idx returns to 0 in IDLE.
- start while busy is ignored; it is not queued.
- Latency: a step whose unit asserts done in its first WAIT cycle costs 2 cycles.
  - Start sampled at cycle 0 -> first LAUNCH at cycle 1.
  - With zero-latency units: done at cycle 2*NUM_ROUNDS*NUM_STEPS+1 (cycle 241 for defaults).
  - busy=0 from the following cycle.
- Counters never wrap:
  - round_idx max is NUM_ROUNDS-1.
  - step max is NUM_STEPS-1.
- step_en is one-hot or zero at all times.

Optional Feature:
Macro STEP_TIMEOUT_EN.
- Defined:
  - A wait counter clears on WAIT entry and increments each WAIT cycle without step_done[step].
  - When it reaches TIMEOUT_CYCLES, timeout_err is set (sticky) and the FSM goes to IDLE.
  - step_en=0, busy=0, and no done pulse is issued.
  - timeout_err clears on rst or on the next accepted start.
- Not defined:
  - The counter is not built; WAIT waits indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Default params, responder asserts step_done[i] whenever step_en[i]=1; start pulse at cycle 0 -> step_en walks 0..4 per round for 24 rounds; round_idx 0..23; LAUNCH gap with step_en=0 between steps; done=1 exactly at cycle 241; busy=0 at cycle 242.
- Unit 3 done 7 cycles after its enable, others immediate, NUM_ROUNDS=2 -> step_en[3] high 7 cycles per round; done at cycle 2*2*5+1+2*6=33.
- step_done=5'b00100 while step 0 active -> no advance; mem_sel stays 0 until step_done[0].
- start pulsed mid-run -> ignored, exactly one done; start and rst in the same cycle from IDLE -> stays IDLE, busy=0.
- rst asserted at round 10 step 2 -> next cycle all outputs 0; a new start restarts at round_idx=0, step 0.
- STEP_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, unit 1 never done -> timeout_err=1 16 cycles after WAIT entry; step_en=0, busy=0, done never pulses; next start clears timeout_err.
